// File: rtl/clkdiv_pkg.sv
// Shared constants and the per-channel state record for the multi-channel divider.
package clkdiv_pkg;

    // Widest counter/divisor a channel can hold
    localparam int unsigned CNT_W_DEF     = 24;

    // Divisor values with special meaning
    localparam int unsigned DIV_HALT      = 0;
    localparam int unsigned DIV_TICK_ONLY = 1;

    // Architectural state of one channel
    typedef struct packed {
        logic [CNT_W_DEF-1:0] cnt;
        logic [CNT_W_DEF-1:0] div;
        logic [CNT_W_DEF-1:0] shadow;
        logic                 pend;
    } ch_state_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: phase counter, shadowed divisor with boundary update,
// and registered square-wave / tick outputs derived from the next state.
// CNT_W must lie in 1..CNT_W_DEF.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_div_val,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pend
);

    localparam int unsigned   SW      = CNT_W_DEF;
    localparam logic [SW-1:0] DIV_RST = SW'(DEFAULT_DIV);
    localparam logic [SW-1:0] D_HALT  = SW'(DIV_HALT);
    localparam logic [SW-1:0] D_ONE   = SW'(DIV_TICK_ONLY);
    localparam ch_state_t     ST_RST  = '{cnt: SW'(0), div: DIV_RST, shadow: DIV_RST, pend: 1'b0};

    ch_state_t     st_q;
    ch_state_t     st_d;
    logic [SW-1:0] wval;
    logic          wrap;
    logic          direct;
    logic          clk_d;
    logic          tick_d;

    // Next-state: sync, idle or degenerate divisors take writes at once; otherwise shadow until wrap
    always_comb begin
        st_d   = st_q;
        wval   = SW'(i_div_val);
        wrap   = (st_q.cnt == (st_q.div - SW'(1)));
        direct = i_sync || !i_en || (st_q.div == D_HALT) || (st_q.div == D_ONE);

        if (direct) begin
            st_d.cnt  = SW'(0);
            st_d.pend = 1'b0;
            if (i_we) begin
                st_d.div    = wval;
                st_d.shadow = wval;
            end else if (st_q.pend) begin
                st_d.div = st_q.shadow;
            end
        end else begin
            if (wrap) begin
                st_d.cnt = SW'(0);
                if (st_q.pend) begin
                    st_d.div  = st_q.shadow;
                    st_d.pend = 1'b0;
                end
            end else begin
                st_d.cnt = st_q.cnt + SW'(1);
            end
            // A write landing on the wrap edge waits for the following wrap
            if (i_we) begin
                st_d.shadow = wval;
                st_d.pend   = 1'b1;
            end
        end
    end

    // Output decode from the next state so outputs move with the state they reflect
    always_comb begin
        clk_d  = 1'b0;
        tick_d = 1'b0;
        if (i_en) begin
            if (st_d.div == D_ONE) begin
                tick_d = 1'b1;
            end else if (st_d.div != D_HALT) begin
                clk_d  = (st_d.cnt >= (st_d.div >> 1));
                tick_d = (st_d.cnt == (st_d.div - SW'(1)));
            end
        end
    end

    // State and output flops
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_RST;
            o_clk  <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            st_q   <= st_d;
            o_clk  <= clk_d;
            o_tick <= tick_d;
        end
    end

    assign o_pend = st_q.pend;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock/tick divider with glitch-free divisor
// updates and a global phase-align pulse.
module clk_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                                      i_clk,
    input  logic                                      rst_n,
    input  logic [N_CH-1:0]                           i_en,
    input  logic                                      i_sync,
    input  logic                                      i_div_we,
    input  logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0]    i_div_ch,
    input  logic [CNT_W-1:0]                          i_div_val,
    output logic [N_CH-1:0]                           o_clk,
    output logic [N_CH-1:0]                           o_tick,
    output logic [N_CH-1:0]                           o_pend
);

    localparam int unsigned CH_W = $clog2(N_CH > 1 ? N_CH : 2);

    logic [N_CH-1:0] ch_we;

    // Per-channel write decode and channel instances; unmatched channel numbers write nothing
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign ch_we[c] = i_div_we && (i_div_ch == CH_W'(c));

        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk     (i_clk),
            .rst_n     (rst_n),
            .i_en      (i_en[c]),
            .i_sync    (i_sync),
            .i_we      (ch_we[c]),
            .i_div_val (i_div_val),
            .o_clk     (o_clk[c]),
            .o_tick    (o_tick[c]),
            .o_pend    (o_pend[c])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Scoreboard bench for clk_divider_multi: stimulus queues the expected
// outputs for each edge, a monitor compares them just after that edge.
module tb_clk_divider_multi;

    logic        i_clk;
    logic        rst_n;
    logic [3:0]  i_en;
    logic        i_sync;
    logic        i_div_we;
    logic [1:0]  i_div_ch;
    logic [23:0] i_div_val;
    logic [3:0]  o_clk;
    logic [3:0]  o_tick;
    logic [3:0]  o_pend;

    clk_divider_multi #(
        .N_CH        (4),
        .CNT_W       (24),
        .DEFAULT_DIV (2)
    ) dut (
        .i_clk     (i_clk),
        .rst_n     (rst_n),
        .i_en      (i_en),
        .i_sync    (i_sync),
        .i_div_we  (i_div_we),
        .i_div_ch  (i_div_ch),
        .i_div_val (i_div_val),
        .o_clk     (o_clk),
        .o_tick    (o_tick),
        .o_pend    (o_pend)
    );

    typedef struct {
        string      name;
        logic [3:0] c, t, p;
        logic [3:0] cm, tm, pm;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input string nm, input logic [3:0] c, input logic [3:0] t,
                        input logic [3:0] p, input logic [3:0] cm, input logic [3:0] tm,
                        input logic [3:0] pm);
        exp_t e;
        e.name = nm; e.c = c; e.t = t; e.p = p; e.cm = cm; e.tm = tm; e.pm = pm;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] req);
        n_total++;
        if (got !== req)
            $display("FAIL %s @%0t: got %h required %h", nm, $time, got, req);
        else
            n_pass++;
    endtask

    // Monitor: compare queued expectations just after each active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_total++;
                if (((o_clk & e.cm) !== (e.c & e.cm)) ||
                    ((o_tick & e.tm) !== (e.t & e.tm)) ||
                    ((o_pend & e.pm) !== (e.p & e.pm)))
                    $display("FAIL %s @%0t: clk %b req %b, tick %b req %b, pend %b req %b (masks %b %b %b)",
                             e.name, $time, o_clk, e.c, o_tick, e.t, o_pend, e.p, e.cm, e.tm, e.pm);
                else
                    n_pass++;
            end
        end
    end

    // Release reset with all channels enabled; DEFAULT_DIV=2 toggles every edge
    task automatic run_default(input string nm, input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge i_clk);
            if (k == 1) begin
                rst_n = 1'b1;
                i_en  = 4'hF;
            end
            push(nm, (k % 2 == 1) ? 4'hF : 4'h0, (k % 2 == 1) ? 4'hF : 4'h0, 4'h0,
                 4'hF, 4'hF, 4'hF);
        end
    endtask

    logic [19:0] p1c, p1t, p2c, p2t;
    logic [17:0] p0c, p0t, p0p;
    logic [11:0] s0c, s0t, s1c, s1t, s2c, s2t, s3c, s3t;
    logic [4:0]  h0c, h0t;
    logic [3:0]  ec, et, ep;

    initial begin
        rst_n     = 1'b0;
        i_en      = 4'h0;
        i_sync    = 1'b0;
        i_div_we  = 1'b0;
        i_div_ch  = 2'd0;
        i_div_val = 24'd0;

        // Reset state
        repeat (2) @(negedge i_clk);
        chk("reset_state", {o_clk, o_tick, o_pend}, 12'h000);
        run_default("rst_default", 8);

        // Divisor decode: program ch1=10, ch2=5 while disabled
        @(negedge i_clk);
        i_en = 4'h0;
        push("disable", 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF);
        @(negedge i_clk);
        i_div_we = 1'b1; i_div_ch = 2'd1; i_div_val = 24'd10;
        push("wr_dis_ch1", 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF);
        @(negedge i_clk);
        i_div_ch = 2'd2; i_div_val = 24'd5;
        push("wr_dis_ch2", 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF);
        p1c = 20'b0000_1111_1000_0011_1110;
        p1t = 20'b0000_0000_1000_0000_0010;
        p2c = 20'b0111_0011_1001_1100_1110;
        p2t = 20'b0001_0000_1000_0100_0010;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            i_div_we = 1'b0;
            i_en     = 4'b0110;
            ec = {1'b0, p2c[19], p1c[19], 1'b0};
            et = {1'b0, p2t[19], p1t[19], 1'b0};
            p1c = p1c << 1; p1t = p1t << 1; p2c = p2c << 1; p2t = p2t << 1;
            push("decode_d10_d5", ec, et, 4'h0, 4'hF, 4'hF, 4'hF);
        end

        // Shadow update: ch0 at D=10, write D=4 landing at cnt=3
        @(negedge i_clk);
        i_en = 4'h0;
        i_div_we = 1'b1; i_div_ch = 2'd0; i_div_val = 24'd10;
        push("wr_dis_ch0", 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF);
        p0c = 18'b00_0011_1110_0110_0110;
        p0t = 18'b00_0000_0010_0010_0010;
        p0p = 18'b00_1111_1110_0000_0000;
        for (int k = 1; k <= 18; k++) begin
            @(negedge i_clk);
            i_en      = 4'b0001;
            i_div_we  = (k == 3);
            i_div_val = 24'd4;
            ec = {3'b000, p0c[17]};
            et = {3'b000, p0t[17]};
            ep = {3'b000, p0p[17]};
            p0c = p0c << 1; p0t = p0t << 1; p0p = p0p << 1;
            push("shadow_d10_to_d4", ec, et, ep, 4'hF, 4'hF, 4'hF);
        end

        // Mixed phases with ch1 pending D=8, then sync plus direct write ch3=6
        for (int m = 1; m <= 7; m++) begin
            @(negedge i_clk);
            i_en      = 4'hF;
            i_div_we  = (m == 2);
            i_div_ch  = 2'd1;
            i_div_val = 24'd8;
            push("pend_before_sync", 4'h0, 4'h0, (m >= 2) ? 4'b0010 : 4'b0000,
                 4'h0, 4'h0, 4'hF);
        end
        @(negedge i_clk);
        i_sync = 1'b1; i_div_we = 1'b1; i_div_ch = 2'd3; i_div_val = 24'd6;
        push("sync_edge", 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF);
        s0c = 12'b0110_0110_0110; s0t = 12'b0010_0010_0010;
        s1c = 12'b0001_1110_0001; s1t = 12'b0000_0010_0000;
        s2c = 12'b0111_0011_1001; s2t = 12'b0001_0000_1000;
        s3c = 12'b0011_1000_1110; s3t = 12'b0000_1000_0010;
        for (int k = 1; k <= 12; k++) begin
            @(negedge i_clk);
            i_sync = 1'b0; i_div_we = 1'b0;
            ec = {s3c[11], s2c[11], s1c[11], s0c[11]};
            et = {s3t[11], s2t[11], s1t[11], s0t[11]};
            s0c = s0c << 1; s0t = s0t << 1; s1c = s1c << 1; s1t = s1t << 1;
            s2c = s2c << 1; s2t = s2t << 1; s3c = s3c << 1; s3t = s3t << 1;
            push("after_sync", ec, et, 4'h0, 4'hF, 4'hF, 4'hF);
        end

        // Edge divisors: ch0 halted (D=0), ch1 tick-only (D=1)
        @(negedge i_clk);
        i_en = 4'b1100;
        push("disable_running", 4'h0, 4'h0, 4'h0, 4'b0011, 4'b0011, 4'b0011);
        @(negedge i_clk);
        i_div_we = 1'b1; i_div_ch = 2'd0; i_div_val = 24'd0;
        push("wr_d0", 4'h0, 4'h0, 4'h0, 4'b0011, 4'b0011, 4'b0011);
        @(negedge i_clk);
        i_div_ch = 2'd1; i_div_val = 24'd1;
        push("wr_d1", 4'h0, 4'h0, 4'h0, 4'b0011, 4'b0011, 4'b0011);
        for (int k = 1; k <= 6; k++) begin
            @(negedge i_clk);
            i_div_we = 1'b0;
            i_en     = 4'hF;
            push("d0_d1_const", 4'h0, 4'b0010, 4'h0, 4'b0011, 4'b0011, 4'b0011);
        end
        // A write to a halted, enabled channel takes effect at once
        h0c = 5'b01101;
        h0t = 5'b00100;
        for (int k = 0; k <= 4; k++) begin
            @(negedge i_clk);
            i_div_we  = (k == 0);
            i_div_ch  = 2'd0;
            i_div_val = 24'd3;
            ec = {3'b000, h0c[4]};
            et = {2'b00, 1'b1, h0t[4]};
            h0c = h0c << 1; h0t = h0t << 1;
            push("halt_to_d3", ec, et, 4'h0, 4'b0011, 4'b0011, 4'b0011);
        end

        // Async reset mid-period and with ch2 pending
        @(negedge i_clk);
        i_div_we = 1'b1; i_div_ch = 2'd2; i_div_val = 24'd7;
        push("pend_before_rst", 4'h0, 4'b0010, 4'b0100, 4'h0, 4'b0010, 4'hF);
        @(negedge i_clk);
        i_div_we = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {o_clk, o_tick, o_pend}, 12'h000);
        repeat (2) @(negedge i_clk);
        chk("held_rst_outputs", {o_clk, o_tick, o_pend}, 12'h000);
        run_default("post_rst_default", 6);

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge i_clk);
        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
